count_chunk_scheduler: RTL and testbench

//  Sequences the shared 32-lane bit-serial count engine (3-phase MSB-first plane walk, 16-bit signed sum).

---
 rtl/count_sched_pkg.sv | 32 +++
 rtl/count_sched_tagq.sv | 40 ++++
 rtl/count_chunk_scheduler.sv | 109 ++++++++++
 tb/tb_count_chunk_scheduler.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_sched_pkg.sv
// Shared constants and types for the count-engine chunk scheduler.
// Phase encoding mirrors the engine's 3-phase MSB-first plane walk.
package count_sched_pkg;

   localparam logic [1:0] PH_0 = 2'd0;
   localparam logic [1:0] PH_1 = 2'd1;
   localparam logic [1:0] PH_2 = 2'd2;

   localparam int LANES      = 32;
   localparam int LANE_W     = 4;
   localparam int CHUNK_W    = LANES * LANE_W;
   localparam int ENG_SUM_W  = 16;
   localparam int SAMPLE_LAG = 5;
   // One window is 3 cycles, so this many tags can be outstanding at once.
   localparam int TAG_DEPTH  = (SAMPLE_LAG + 2) / 3;

   typedef struct packed {
      logic valid;
      logic last;
   } tag_t;

   function automatic logic [1:0] ph_next(input logic [1:0] ph);
      logic [1:0] nxt;
      case (ph)
         PH_2:    nxt = PH_0;
         PH_0:    nxt = PH_1;
         default: nxt = PH_2;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/count_sched_tagq.sv
// Shift queue of window tags: a tag enters at every ph2 edge and is consumed
// at the second ph1 edge after it, when its engine sum is sampled.
module count_sched_tagq
   import count_sched_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  tag_t push_tag,
   input  logic pop,
   output tag_t head,
   output logic last_inflight,
   output logic any_inflight
);

   tag_t q [TAG_DEPTH];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < TAG_DEPTH; i++) q[i] <= '0;
      end else if (push) begin
         q[0] <= push_tag;
         for (int i = 1; i < TAG_DEPTH; i++) q[i] <= q[i-1];
      end else if (pop) begin
         q[TAG_DEPTH-1] <= '0;
      end
   end

   assign head = q[TAG_DEPTH-1];

   always_comb begin
      last_inflight = 1'b0;
      any_inflight  = 1'b0;
      for (int i = 0; i < TAG_DEPTH; i++) begin
         last_inflight = last_inflight | (q[i].valid & q[i].last);
         any_inflight  = any_inflight  | q[i].valid;
      end
   end

endmodule

// File: rtl/count_chunk_scheduler.sv
// Holds each chunk on the bit-serial count engine for one 3-cycle window and accumulates the
// sampled engine sums into one dot product per job. Define ACC_SAT_EN for saturating accumulation.
module count_chunk_scheduler
   import count_sched_pkg::*;
#(
   parameter int ACC_W = 24
)(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic                        in_last,
   input  logic [CHUNK_W-1:0]          in_weight,
   input  logic [CHUNK_W-1:0]          in_act,
   output logic [CHUNK_W-1:0]          eng_weight,
   output logic [CHUNK_W-1:0]          eng_act,
   input  logic signed [ENG_SUM_W-1:0] eng_sum,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic signed [ACC_W-1:0]     out_sum,
   output logic                        out_ovf,
   output logic                        busy
);

   // Handshakes: a transfer happens on the clk edge where valid && ready; in_ready depends only on
   // internal state, and out_valid/out_sum hold steady until out_ready completes the transfer.
   logic [1:0]       ph;
   logic             accept, sample, last_inflight, any_inflight;
   tag_t             push_tag, head;
   logic [ACC_W-1:0] acc, acc_next, sum_ext;

   assign in_ready = (ph == PH_2) && !out_valid && !last_inflight;
   assign accept   = in_valid && in_ready;
   assign push_tag = '{valid: accept, last: accept && in_last};
   assign sample   = (ph == PH_1) && head.valid;
   assign busy     = any_inflight || out_valid;
   assign sum_ext  = ACC_W'(eng_sum);

   count_sched_tagq u_tagq (
      .clk           (clk),
      .rst           (rst),
      .push          (ph == PH_2),
      .push_tag      (push_tag),
      .pop           (ph == PH_1),
      .head          (head),
      .last_inflight (last_inflight),
      .any_inflight  (any_inflight)
   );

`ifdef ACC_SAT_EN
   logic [ACC_W:0] acc_wide;
   logic           clamp, ovf_acc;

   assign acc_wide = {acc[ACC_W-1], acc} + {sum_ext[ACC_W-1], sum_ext};
   assign clamp    = acc_wide[ACC_W] != acc_wide[ACC_W-1];

   always_comb begin
      acc_next = acc_wide[ACC_W-1:0];
      if (clamp)
         acc_next = acc_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf_acc <= 1'b0;
         out_ovf <= 1'b0;
      end else if (sample) begin
         if (head.last) begin
            out_ovf <= ovf_acc | clamp;
            ovf_acc <= 1'b0;
         end else begin
            ovf_acc <= ovf_acc | clamp;
         end
      end
   end
`else
   assign acc_next = acc + sum_ext;
   assign out_ovf  = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ph         <= PH_2;
         eng_weight <= '0;
         eng_act    <= '0;
         acc        <= '0;
         out_valid  <= 1'b0;
         out_sum    <= '0;
      end else begin
         ph <= ph_next(ph);
         // Idle windows feed zeros so the engine never sees stale operands.
         if (ph == PH_2) begin
            eng_weight <= accept ? in_weight : '0;
            eng_act    <= accept ? in_act    : '0;
         end
         if (out_valid && out_ready) out_valid <= 1'b0;
         if (sample) begin
            if (head.last) begin
               out_sum   <= acc_next;
               out_valid <= 1'b1;
               acc       <= '0;
            end else begin
               acc <= acc_next;
            end
         end
      end
   end

endmodule

// File: tb/tb_count_chunk_scheduler.sv
// Bench for count_chunk_scheduler: engine stub derives the sum from a stable 3-cycle window,
// a job-level arithmetic model predicts results for a 24-bit and a 16-bit instance.
module tb_count_chunk_scheduler;
   import count_sched_pkg::*;

   localparam int AW = 24;
   localparam int NW = 16;
   localparam logic [15:0] KEY = 16'h5a5a;
`ifdef ACC_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic                 clk, rst, in_valid, in_last, out_ready;
   logic [127:0]         in_weight, in_act;
   logic signed [15:0]   eng_sum;
   logic                 a_in_ready, a_out_valid, a_out_ovf, a_busy;
   logic [127:0]         a_eng_weight, a_eng_act;
   logic signed [AW-1:0] a_out_sum;
   logic                 b_in_ready, b_out_valid, b_out_ovf, b_busy;
   logic [127:0]         b_eng_weight, b_eng_act;
   logic signed [NW-1:0] b_out_sum;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   logic [AW-1:0] exp_q[$];
   logic [NW-1:0] exp16_q[$];
   logic [1:0]    exp_ovf_q[$];
   logic [NW-1:0] last_b_sum;
   logic          last_b_ovf;

   count_chunk_scheduler #(.ACC_W(AW)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_last(in_last),
      .in_weight(in_weight), .in_act(in_act), .eng_weight(a_eng_weight), .eng_act(a_eng_act),
      .eng_sum(eng_sum), .out_valid(a_out_valid), .out_ready(out_ready), .out_sum(a_out_sum),
      .out_ovf(a_out_ovf), .busy(a_busy)
   );

   count_chunk_scheduler #(.ACC_W(NW)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_last(in_last),
      .in_weight(in_weight), .in_act(in_act), .eng_weight(b_eng_weight), .eng_act(b_eng_act),
      .eng_sum(eng_sum), .out_valid(b_out_valid), .out_ready(out_ready), .out_sum(b_out_sum),
      .out_ovf(b_out_ovf), .busy(b_busy)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Engine stub: a sum is only meaningful once the operands stayed put for a whole window;
   // any other sampling moment returns an obviously wrong value.
   logic [255:0] d1 = '0, d2 = '0, d3 = '0, d4 = '0;
   always @(posedge clk) begin
      d1 <= {a_eng_act, a_eng_weight};
      d2 <= d1;
      d3 <= d2;
      d4 <= d3;
   end
   assign eng_sum = (d2 == d3 && d3 == d4) ? signed'(d2[15:0] ^ KEY) : 16'sh8001;

   // ---------------- reference model ----------------
   function automatic longint model(input int sums[$], input int w, input bit sat, output bit ovf);
      longint acc  = 0;
      longint hi   = (longint'(1) <<< (w - 1)) - 1;
      longint lo   = -(longint'(1) <<< (w - 1));
      longint span = longint'(1) <<< w;
      ovf = 1'b0;
      foreach (sums[i]) begin
         acc += sums[i];
         if (sat) begin
            if (acc > hi) begin acc = hi; ovf = 1'b1; end
            else if (acc < lo) begin acc = lo; ovf = 1'b1; end
         end else begin
            while (acc > hi) acc -= span;
            while (acc < lo) acc += span;
         end
      end
      return acc;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic plan_job(input int sums[$]);
      bit oa, ob;
      longint ra, rb;
      ra = model(sums, AW, SAT, oa);
      rb = model(sums, NW, SAT, ob);
      exp_q.push_back(ra[AW-1:0]);
      exp16_q.push_back(rb[NW-1:0]);
      exp_ovf_q.push_back({oa, ob});
   endtask

   // ---------------- drivers ----------------
   task automatic send_chunk(input logic [127:0] w, input logic [127:0] a, input bit last,
                             output int acc_cyc);
      int n = 0;
      in_valid = 1'b1; in_weight = w; in_act = a; in_last = last;
      while (!a_in_ready && n < 40) begin @(negedge clk); n++; end
      n_checks++;
      if (a_in_ready !== 1'b1) $display("FAIL accept_timeout: in_ready=%b want 1 within 40 cycles", a_in_ready);
      else n_pass++;
      @(posedge clk); #1;
      acc_cyc = cyc;
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic run_job(input int sums[$], input int gap_max);
      logic [127:0] w, a;
      int t;
      plan_job(sums);
      foreach (sums[i]) begin
         w = rand128(); w[15:0] = 16'(sums[i]) ^ KEY; a = rand128();
         send_chunk(w, a, i == sums.size() - 1, t);
         if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
      end
   endtask

   // Scoreboard: wait for a result, compare against the queued expectation, optionally hold it off.
   task automatic collect(input string name, input int hold, output int rise_cyc);
      int n = 0;
      bit bad = 1'b0;
      logic [AW-1:0] ea, held;
      logic [NW-1:0] eb;
      logic [1:0]    eo;
      while (!a_out_valid && n < 40) begin @(negedge clk); n++; end
      rise_cyc = cyc;
      ea = exp_q.pop_front(); eb = exp16_q.pop_front(); eo = exp_ovf_q.pop_front();
      n_checks++;
      if (a_out_valid !== 1'b1 || b_out_valid !== 1'b1)
         $display("FAIL %s_valid: out_valid a=%b b=%b want 1 1", name, a_out_valid, b_out_valid);
      else n_pass++;
      n_checks++;
      if (a_out_sum !== ea) $display("FAIL %s_sum24: got %0d want %0d", name, a_out_sum, $signed(ea));
      else n_pass++;
      n_checks++;
      if (b_out_sum !== eb) $display("FAIL %s_sum16: got %0d want %0d", name, b_out_sum, $signed(eb));
      else n_pass++;
      n_checks++;
      if ({a_out_ovf, b_out_ovf} !== eo)
         $display("FAIL %s_ovf: got a=%b b=%b want a=%b b=%b", name, a_out_ovf, b_out_ovf, eo[1], eo[0]);
      else n_pass++;
      last_b_sum = b_out_sum; last_b_ovf = b_out_ovf;
      if (hold > 0) begin
         held = a_out_sum;
         in_valid = 1'b1; in_weight = rand128(); in_act = rand128(); in_last = 1'b0;
         repeat (hold) begin
            @(negedge clk);
            if (a_in_ready !== 1'b0 || b_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out_sum !== held)
               bad = 1'b1;
         end
         in_valid = 1'b0;
         n_checks++;
         if (bad) $display("FAIL %s_hold: in_ready=%b out_valid=%b sum=%0d want 0 1 %0d",
                           name, a_in_ready, a_out_valid, a_out_sum, $signed(held));
         else n_pass++;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_checks++;
      if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0)
         $display("FAIL %s_release: out_valid a=%b b=%b want 0 0", name, a_out_valid, b_out_valid);
      else n_pass++;
      @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      in_weight = '0; in_act = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({a_out_valid, a_out_ovf, a_busy} !== 3'b000 || a_out_sum !== '0 ||
          a_eng_weight !== '0 || a_eng_act !== '0)
         $display("FAIL reset_outputs: valid=%b ovf=%b busy=%b sum=%0d want all 0",
                  a_out_valid, a_out_ovf, a_busy, a_out_sum);
      else n_pass++;
      rst = 1'b1;
      n_checks++;
      if (a_in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", a_in_ready);
      else n_pass++;
   endtask

   task automatic test_single();
      int sums[$];
      logic [127:0] w, a;
      int t_acc, t_rise;
      sums = '{100};
      plan_job(sums);
      w = rand128(); w[15:0] = 16'd100 ^ KEY; a = rand128();
      send_chunk(w, a, 1'b1, t_acc);
      collect("single", 0, t_rise);
      n_checks++;
      if (t_rise - t_acc != SAMPLE_LAG)
         $display("FAIL single_latency: got %0d cycles want %0d", t_rise - t_acc, SAMPLE_LAG);
      else n_pass++;
   endtask

   task automatic test_four();
      int sums[$];
      logic [127:0] w, a;
      int t[4];
      int r;
      sums = '{100, -50, 7, -3};
      plan_job(sums);
      foreach (sums[i]) begin
         w = rand128(); w[15:0] = 16'(sums[i]) ^ KEY; a = rand128();
         send_chunk(w, a, i == 3, t[i]);
      end
      n_checks++;
      if (t[1] - t[0] != 3 || t[2] - t[1] != 3 || t[3] - t[2] != 3)
         $display("FAIL four_spacing: got %0d %0d %0d want 3 3 3", t[1] - t[0], t[2] - t[1], t[3] - t[2]);
      else n_pass++;
      collect("four", 0, r);
   endtask

   task automatic test_acc_cleared(input string name);
      int sums[$];
      int r;
      sums = '{-1};
      run_job(sums, 0);
      collect(name, 0, r);
   endtask

   task automatic test_backpressure();
      int sums[$];
      int r;
      sums = '{1000, 2000, -300};
      run_job(sums, 0);
      collect("bp", 20, r);
      sums = '{5, 6};
      run_job(sums, 0);
      collect("bp_resume", 0, r);
   endtask

   task automatic test_gaps();
      int sums[$];
      logic [127:0] w, a;
      int t;
      sums = '{1234, -777, 42, 3000};
      plan_job(sums);
      foreach (sums[i]) begin
         w = rand128(); w[15:0] = 16'(sums[i]) ^ KEY; a = rand128();
         send_chunk(w, a, i == sums.size() - 1, t);
         n_checks++;
         if (a_eng_weight !== w || a_eng_act !== a)
            $display("FAIL gaps_eng_load: weight=%h want %h", a_eng_weight, w);
         else n_pass++;
         repeat (3) @(negedge clk);
         n_checks++;
         if (a_eng_weight !== '0 || a_eng_act !== '0)
            $display("FAIL gaps_eng_idle: weight=%h act=%h want 0", a_eng_weight, a_eng_act);
         else n_pass++;
         repeat ($urandom_range(0, 4)) @(negedge clk);
      end
      collect("gaps", 0, t);
   endtask

   task automatic test_saturate();
      int sums[$];
      int r;
      logic [NW-1:0] want_sum;
      logic          want_ovf;
`ifdef ACC_SAT_EN
      want_sum = 16'h7fff; want_ovf = 1'b1;
`else
      want_sum = 16'hea60; want_ovf = 1'b0;
`endif
      sums = '{30000, 30000};
      run_job(sums, 0);
      collect("sat", 0, r);
      n_checks++;
      if (last_b_sum !== want_sum || last_b_ovf !== want_ovf)
         $display("FAIL sat_const: got sum=%0d ovf=%b want sum=%0d ovf=%b",
                  $signed(last_b_sum), last_b_ovf, $signed(want_sum), want_ovf);
      else n_pass++;
      test_acc_cleared("sat_after");
   endtask

   task automatic test_reset_mid_job();
      logic [127:0] w, a;
      int t;
      for (int i = 0; i < 2; i++) begin
         w = rand128(); w[15:0] = 16'(500 + i) ^ KEY; a = rand128();
         send_chunk(w, a, 1'b0, t);
      end
      n_checks++;
      if (a_busy !== 1'b1) $display("FAIL midrst_busy_before: got %b want 1", a_busy);
      else n_pass++;
      rst = 1'b0; #1;
      n_checks++;
      if ({a_out_valid, a_out_ovf, a_busy, b_busy} !== 4'b0000 || a_out_sum !== '0 ||
          a_eng_weight !== '0 || a_eng_act !== '0)
         $display("FAIL midrst_outputs: valid=%b ovf=%b busy=%b eng=%h want all 0",
                  a_out_valid, a_out_ovf, a_busy, a_eng_weight);
      else n_pass++;
      @(negedge clk);
      rst = 1'b1;
      n_checks++;
      if (a_in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %b want 1", a_in_ready);
      else n_pass++;
   endtask

   task automatic test_random();
      int sums[$];
      int r;
      for (int j = 0; j < 12; j++) begin
         sums.delete();
         repeat ($urandom_range(1, 6)) sums.push_back(int'($urandom_range(0, 65535)) - 32768);
         run_job(sums, 3);
         collect("rand", $urandom_range(0, 3), r);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_four();
      test_acc_cleared("four_after");
      test_backpressure();
      test_gaps();
      test_saturate();
      test_reset_mid_job();
      test_acc_cleared("midrst_after");
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
